// File: rtl/uart_rx_core_if.sv
// -----------------------------------------------------------------------------
// uart_rx_core_if
// Control and status bundle between the UART register block and the receive
// engine.
//   rx_en_i      : receiver enable (register block -> core)
//   baud_div_i   : clock cycles per bit (register block -> core)
//   rx_data_o    : last good byte (core -> register block)
//   rx_over_o    : one-cycle strobe, good frame received
//   rx_busy_o    : receiver is inside a frame (or a line break)
//   frame_err_o  : one-cycle strobe, stop bit read as 0
//   parity_err_o : one-cycle strobe, even-parity mismatch
// master = register block side, slave = uart_rx_core.
// -----------------------------------------------------------------------------
interface uart_rx_core_if;
    logic        rx_en_i;
    logic [31:0] baud_div_i;
    logic [7:0]  rx_data_o;
    logic        rx_over_o;
    logic        rx_busy_o;
    logic        frame_err_o;
    logic        parity_err_o;

    modport master (
        output rx_en_i, baud_div_i,
        input  rx_data_o, rx_over_o, rx_busy_o, frame_err_o, parity_err_o
    );

    modport slave (
        input  rx_en_i, baud_div_i,
        output rx_data_o, rx_over_o, rx_busy_o, frame_err_o, parity_err_o
    );
endinterface

// File: rtl/uart_rx_core.sv
// -----------------------------------------------------------------------------
// uart_rx_core
// Serial receive engine: recovers 8N1 frames (8E1 when UART_RX_PARITY_EN is
// defined) from the uart_rx pin and reports each byte with a one-cycle strobe.
//
// Ports:
//   clk_i    : the only clock
//   rst_n_i  : asynchronous, active-low reset
//   uart_rx  : serial line, asynchronous to clk_i, idles high
//   bus      : uart_rx_core_if.slave (enable, divisor, data and status strobes)
//
// Parameters:
//   SYNC_STAGES : input synchronizer depth (>= 2)
//   MIN_DIV     : divisor floor; smaller baud_div_i values are clamped up
//
// Optional feature macro: UART_RX_PARITY_EN adds an even-parity bit between
// the data and stop bits and makes parity_err_o live; without it parity_err_o
// is tied low.
// -----------------------------------------------------------------------------
module uart_rx_core #(
    parameter int SYNC_STAGES = 2,
    parameter int MIN_DIV     = 4
) (
    input  logic           clk_i,
    input  logic           rst_n_i,
    input  logic           uart_rx,
    uart_rx_core_if.slave  bus
);

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {
        ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP, ST_BREAK
    } state_t;
`else
    typedef enum logic [2:0] {
        ST_IDLE, ST_START, ST_DATA, ST_STOP, ST_BREAK
    } state_t;
`endif

    state_t                 state_reg;
    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   rx_prev_reg;
    logic [31:0]            div_reg;
    logic [31:0]            cnt_reg;
    logic [3:0]             bit_idx_reg;
    logic [7:0]             shift_reg;
    logic [7:0]             rx_data_reg;
    logic                   rx_over_reg;
    logic                   rx_busy_reg;
    logic                   frame_err_reg;
`ifdef UART_RX_PARITY_EN
    logic                   par_bad_reg;
    logic                   parity_err_reg;
`endif

    logic        rx_s;
    logic        rx_fall;
    logic [31:0] div_eff;
    logic        half_hit;
    logic        full_hit;

    assign rx_s     = sync_reg[SYNC_STAGES-1];
    assign rx_fall  = rx_prev_reg & ~rx_s;
    assign div_eff  = (bus.baud_div_i < 32'(MIN_DIV)) ? 32'(MIN_DIV) : bus.baud_div_i;
    assign half_hit = (cnt_reg == (div_reg >> 1) - 32'd1);
    assign full_hit = (cnt_reg == div_reg - 32'd1);

    // Synchronizer and edge-detect flop reset to 1 so that reset release on an
    // idle line never looks like a start edge.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sync_reg    <= '1;
            rx_prev_reg <= 1'b1;
        end else begin
            sync_reg    <= {sync_reg[SYNC_STAGES-2:0], uart_rx};
            rx_prev_reg <= rx_s;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_reg      <= ST_IDLE;
            div_reg        <= 32'(MIN_DIV);
            cnt_reg        <= '0;
            bit_idx_reg    <= '0;
            shift_reg      <= '0;
            rx_data_reg    <= '0;
            rx_over_reg    <= 1'b0;
            rx_busy_reg    <= 1'b0;
            frame_err_reg  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad_reg    <= 1'b0;
            parity_err_reg <= 1'b0;
`endif
        end else begin
            // Strobes are high for exactly one cycle.
            rx_over_reg   <= 1'b0;
            frame_err_reg <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err_reg <= 1'b0;
`endif
            if (state_reg != ST_IDLE && !bus.rx_en_i) begin
                // Disabling mid-frame drops the frame silently.
                state_reg   <= ST_IDLE;
                rx_busy_reg <= 1'b0;
            end else begin
                case (state_reg)
                    ST_IDLE: begin
                        if (bus.rx_en_i && rx_fall) begin
                            div_reg     <= div_eff;
                            cnt_reg     <= '0;
                            state_reg   <= ST_START;
                            rx_busy_reg <= 1'b1;
                        end
                    end
                    ST_START: begin
                        // Mid-start-bit check rejects glitches shorter than half a bit.
                        if (half_hit) begin
                            if (rx_s) begin
                                state_reg   <= ST_IDLE;
                                rx_busy_reg <= 1'b0;
                            end else begin
                                cnt_reg     <= '0;
                                bit_idx_reg <= '0;
                                state_reg   <= ST_DATA;
                            end
                        end else begin
                            cnt_reg <= cnt_reg + 32'd1;
                        end
                    end
                    ST_DATA: begin
                        if (full_hit) begin
                            shift_reg <= {rx_s, shift_reg[7:1]};
                            cnt_reg   <= '0;
                            if (bit_idx_reg == 4'd7) begin
`ifdef UART_RX_PARITY_EN
                                state_reg <= ST_PARITY;
`else
                                state_reg <= ST_STOP;
`endif
                            end else begin
                                bit_idx_reg <= bit_idx_reg + 4'd1;
                            end
                        end else begin
                            cnt_reg <= cnt_reg + 32'd1;
                        end
                    end
`ifdef UART_RX_PARITY_EN
                    ST_PARITY: begin
                        if (full_hit) begin
                            // Even parity: data bits plus parity bit XOR to zero.
                            par_bad_reg <= rx_s ^ (^shift_reg);
                            cnt_reg     <= '0;
                            state_reg   <= ST_STOP;
                        end else begin
                            cnt_reg <= cnt_reg + 32'd1;
                        end
                    end
`endif
                    ST_STOP: begin
                        if (full_hit) begin
                            if (rx_s) begin
`ifdef UART_RX_PARITY_EN
                                if (par_bad_reg) begin
                                    parity_err_reg <= 1'b1;
                                end else begin
                                    rx_data_reg <= shift_reg;
                                    rx_over_reg <= 1'b1;
                                end
`else
                                rx_data_reg <= shift_reg;
                                rx_over_reg <= 1'b1;
`endif
                                state_reg   <= ST_IDLE;
                                rx_busy_reg <= 1'b0;
                            end else begin
                                // Framing error outranks parity; wait out the break.
                                frame_err_reg <= 1'b1;
                                state_reg     <= ST_BREAK;
                            end
                        end else begin
                            cnt_reg <= cnt_reg + 32'd1;
                        end
                    end
                    ST_BREAK: begin
                        if (rx_s) begin
                            state_reg   <= ST_IDLE;
                            rx_busy_reg <= 1'b0;
                        end
                    end
                    default: begin
                        state_reg   <= ST_IDLE;
                        rx_busy_reg <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.rx_data_o   = rx_data_reg;
    assign bus.rx_over_o   = rx_over_reg;
    assign bus.rx_busy_o   = rx_busy_reg;
    assign bus.frame_err_o = frame_err_reg;
`ifdef UART_RX_PARITY_EN
    assign bus.parity_err_o = parity_err_reg;
`else
    assign bus.parity_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_core.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_core
// Self-checking bench for uart_rx_core. A negedge monitor logs every strobe
// (kind, data, cycle) and the busy edges; each test task drives serial frames
// and compares the log against outcomes computed from the frame rules.
// Timing reference: a pin change driven just after posedge N shows up as
// rx_busy_o high from cycle N+SYNC+1; strobes follow div/2 + 9*div later
// (10*div with parity).
// -----------------------------------------------------------------------------
module tb_uart_rx_core;
    localparam int SYNC    = 2;
    localparam int MIN_DIV = 4;
`ifdef UART_RX_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif

    logic clk     = 1'b0;
    logic rst_n   = 1'b0;
    logic uart_rx = 1'b1;

    uart_rx_core_if bus ();

    uart_rx_core #(.SYNC_STAGES(SYNC), .MIN_DIV(MIN_DIV)) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .uart_rx (uart_rx),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    // Strobe log: kind 0 = good byte, 1 = frame error, 2 = parity error.
    int         ev_kind[$];
    logic [7:0] ev_data[$];
    int         ev_cyc[$];
    int         busy_rise   = -1;
    int         busy_fall   = -1;
    int         busy_cycles = 0;
    logic       busy_q      = 1'b0;

    always @(negedge clk) begin
        if (bus.rx_over_o)    begin ev_kind.push_back(0); ev_data.push_back(bus.rx_data_o); ev_cyc.push_back(cyc); end
        if (bus.frame_err_o)  begin ev_kind.push_back(1); ev_data.push_back(bus.rx_data_o); ev_cyc.push_back(cyc); end
        if (bus.parity_err_o) begin ev_kind.push_back(2); ev_data.push_back(bus.rx_data_o); ev_cyc.push_back(cyc); end
        if (bus.rx_busy_o && !busy_q) busy_rise = cyc;
        if (!bus.rx_busy_o && busy_q) busy_fall = cyc;
        if (bus.rx_busy_o) busy_cycles++;
        busy_q = bus.rx_busy_o;
    end

    int         n_cmp = 0;
    int         n_bad = 0;
    logic [7:0] exp_data = 8'h00;

    // ---------------- reference model ----------------
    function automatic int eff_div(input int baud);
        return (baud < MIN_DIV) ? MIN_DIV : baud;
    endfunction

    function automatic int exp_strobe_cyc(input int n0, input int baud);
        int d;
        d = eff_div(baud);
        return n0 + SYNC + 1 + d / 2 + (PAR ? 10 : 9) * d;
    endfunction

    function automatic int exp_kind(input logic [7:0] d, input bit stop, input bit par);
        if (!stop) return 1;
        if (PAR && (par != ^d)) return 2;
        return 0;
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        ev_kind.delete();
        ev_data.delete();
        ev_cyc.delete();
    endtask

    // Drives one frame; each bit lasts div cycles. Leaves the line at the stop level.
    task automatic send_frame(input logic [7:0] d, input int div, input bit stop,
                              input bit par, input bit scramble, output int n0);
        n0 = cyc;
        uart_rx = 1'b0;
        step(div);
        for (int k = 0; k < 8; k++) begin
            uart_rx = d[k];
            if (scramble && k == 1) bus.baud_div_i = $urandom_range(0, 40);
            step(div);
        end
        if (PAR) begin
            uart_rx = par;
            step(div);
        end
        uart_rx = stop;
        step(div);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        bus.rx_en_i    = 1'b1;
        bus.baud_div_i = 32'd16;
        step(3);
        n_cmp++; if (bus.rx_data_o !== 8'h00) begin n_bad++; $display("FAIL reset_data: got %02h want 00", bus.rx_data_o); end
        n_cmp++; if (bus.rx_over_o !== 1'b0) begin n_bad++; $display("FAIL reset_over: got %b want 0", bus.rx_over_o); end
        n_cmp++; if (bus.rx_busy_o !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", bus.rx_busy_o); end
        n_cmp++; if (bus.frame_err_o !== 1'b0) begin n_bad++; $display("FAIL reset_ferr: got %b want 0", bus.frame_err_o); end
        n_cmp++; if (bus.parity_err_o !== 1'b0) begin n_bad++; $display("FAIL reset_perr: got %b want 0", bus.parity_err_o); end
        rst_n = 1'b1;
        step(3);
        $display("reset: outputs checked");
    endtask

    task automatic test_basic();
        int n0;
        bus.baud_div_i = 32'd16;
        clear_log();
        send_frame(8'hA5, 16, 1'b1, ^8'hA5, 1'b0, n0);
        step(6);
        exp_data = 8'hA5;
        n_cmp++; if (ev_kind.size() !== 1) begin n_bad++; $display("FAIL basic_count: got %0d want 1", ev_kind.size()); end
        if (ev_kind.size() > 0) begin
            n_cmp++; if (ev_kind[0] !== 0) begin n_bad++; $display("FAIL basic_kind: got %0d want 0", ev_kind[0]); end
            n_cmp++; if (ev_data[0] !== 8'hA5) begin n_bad++; $display("FAIL basic_data: got %02h want a5", ev_data[0]); end
            n_cmp++; if (ev_cyc[0] !== exp_strobe_cyc(n0, 16)) begin n_bad++; $display("FAIL basic_cycle: got %0d want %0d", ev_cyc[0], exp_strobe_cyc(n0, 16)); end
        end
        n_cmp++; if (busy_rise !== n0 + SYNC + 1) begin n_bad++; $display("FAIL basic_busy_rise: got %0d want %0d", busy_rise, n0 + SYNC + 1); end
        n_cmp++; if (busy_fall !== exp_strobe_cyc(n0, 16)) begin n_bad++; $display("FAIL basic_busy_fall: got %0d want %0d", busy_fall, exp_strobe_cyc(n0, 16)); end
        n_cmp++; if (bus.rx_data_o !== 8'hA5) begin n_bad++; $display("FAIL basic_hold: got %02h want a5", bus.rx_data_o); end
        $display("basic: sent a5 div 16");
    endtask

    task automatic test_glitch();
        int n0;
        bus.baud_div_i = 32'd16;
        clear_log();
        n0 = cyc;
        uart_rx = 1'b0;
        step(3);
        uart_rx = 1'b1;
        step(30);
        n_cmp++; if (ev_kind.size() !== 0) begin n_bad++; $display("FAIL glitch_count: got %0d want 0", ev_kind.size()); end
        n_cmp++; if (busy_rise !== n0 + SYNC + 1) begin n_bad++; $display("FAIL glitch_busy_rise: got %0d want %0d", busy_rise, n0 + SYNC + 1); end
        n_cmp++; if (busy_fall !== n0 + SYNC + 1 + 8) begin n_bad++; $display("FAIL glitch_busy_fall: got %0d want %0d", busy_fall, n0 + SYNC + 9); end
        n_cmp++; if (bus.rx_data_o !== exp_data) begin n_bad++; $display("FAIL glitch_data: got %02h want %02h", bus.rx_data_o, exp_data); end
        $display("glitch: 3-cycle low pulse");
    endtask

    task automatic test_frame_error();
        int n0;
        bus.baud_div_i = 32'd16;
        clear_log();
        send_frame(8'h3C, 16, 1'b0, ^8'h3C, 1'b0, n0);
        step(100);
        n_cmp++; if (ev_kind.size() !== 1) begin n_bad++; $display("FAIL ferr_count: got %0d want 1", ev_kind.size()); end
        if (ev_kind.size() > 0) begin
            n_cmp++; if (ev_kind[0] !== 1) begin n_bad++; $display("FAIL ferr_kind: got %0d want 1", ev_kind[0]); end
            n_cmp++; if (ev_cyc[0] !== exp_strobe_cyc(n0, 16)) begin n_bad++; $display("FAIL ferr_cycle: got %0d want %0d", ev_cyc[0], exp_strobe_cyc(n0, 16)); end
        end
        n_cmp++; if (bus.rx_data_o !== exp_data) begin n_bad++; $display("FAIL ferr_data_kept: got %02h want %02h", bus.rx_data_o, exp_data); end
        n_cmp++; if (bus.rx_busy_o !== 1'b1) begin n_bad++; $display("FAIL ferr_break_busy: got %b want 1", bus.rx_busy_o); end
        uart_rx = 1'b1;
        step(6);
        n_cmp++; if (bus.rx_busy_o !== 1'b0) begin n_bad++; $display("FAIL ferr_break_exit: got %b want 0", bus.rx_busy_o); end
        clear_log();
        send_frame(8'h81, 16, 1'b1, ^8'h81, 1'b0, n0);
        step(6);
        exp_data = 8'h81;
        n_cmp++; if (ev_kind.size() !== 1) begin n_bad++; $display("FAIL ferr_next_count: got %0d want 1", ev_kind.size()); end
        if (ev_kind.size() > 0) begin
            n_cmp++; if (ev_kind[0] !== 0 || ev_data[0] !== 8'h81) begin n_bad++; $display("FAIL ferr_next_byte: got kind %0d data %02h want kind 0 data 81", ev_kind[0], ev_data[0]); end
        end
        $display("frame_error: 3c bad stop, break, then 81");
    endtask

    task automatic test_back_to_back();
        int n0, n1;
        bus.baud_div_i = 32'd8;
        clear_log();
        send_frame(8'h00, 8, 1'b1, 1'b0, 1'b0, n0);
        send_frame(8'hFF, 8, 1'b1, 1'b0, 1'b0, n1);
        step(6);
        exp_data = 8'hFF;
        n_cmp++; if (ev_kind.size() !== 2) begin n_bad++; $display("FAIL b2b_count: got %0d want 2", ev_kind.size()); end
        if (ev_kind.size() > 1) begin
            n_cmp++; if (ev_kind[0] !== 0 || ev_data[0] !== 8'h00) begin n_bad++; $display("FAIL b2b_first: got kind %0d data %02h want kind 0 data 00", ev_kind[0], ev_data[0]); end
            n_cmp++; if (ev_kind[1] !== 0 || ev_data[1] !== 8'hFF) begin n_bad++; $display("FAIL b2b_second: got kind %0d data %02h want kind 0 data ff", ev_kind[1], ev_data[1]); end
            n_cmp++; if (ev_cyc[1] !== exp_strobe_cyc(n1, 8)) begin n_bad++; $display("FAIL b2b_cycle: got %0d want %0d", ev_cyc[1], exp_strobe_cyc(n1, 8)); end
        end
        $display("back_to_back: 00 then ff div 8");
    endtask

    task automatic test_reset_mid();
        int n0;
        bus.baud_div_i = 32'd16;
        uart_rx = 1'b0; step(16);
        uart_rx = 1'b1; step(16);
        uart_rx = 1'b0; step(5);
        n_cmp++; if (bus.rx_busy_o !== 1'b1) begin n_bad++; $display("FAIL rstmid_busy_before: got %b want 1", bus.rx_busy_o); end
        rst_n = 1'b0;
        uart_rx = 1'b1;
        #2;
        n_cmp++; if (bus.rx_busy_o !== 1'b0) begin n_bad++; $display("FAIL rstmid_busy: got %b want 0", bus.rx_busy_o); end
        n_cmp++; if (bus.rx_data_o !== 8'h00) begin n_bad++; $display("FAIL rstmid_data: got %02h want 00", bus.rx_data_o); end
        n_cmp++; if ({bus.rx_over_o, bus.frame_err_o, bus.parity_err_o} !== 3'b000) begin n_bad++; $display("FAIL rstmid_strobes: got %b want 000", {bus.rx_over_o, bus.frame_err_o, bus.parity_err_o}); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        exp_data = 8'h00;
        step(5);
        clear_log();
        send_frame(8'h5A, 16, 1'b1, ^8'h5A, 1'b0, n0);
        step(6);
        exp_data = 8'h5A;
        n_cmp++; if (ev_kind.size() !== 1) begin n_bad++; $display("FAIL rstmid_next_count: got %0d want 1", ev_kind.size()); end
        if (ev_kind.size() > 0) begin
            n_cmp++; if (ev_kind[0] !== 0 || ev_data[0] !== 8'h5A) begin n_bad++; $display("FAIL rstmid_next_byte: got kind %0d data %02h want kind 0 data 5a", ev_kind[0], ev_data[0]); end
            n_cmp++; if (ev_cyc[0] !== exp_strobe_cyc(n0, 16)) begin n_bad++; $display("FAIL rstmid_next_cycle: got %0d want %0d", ev_cyc[0], exp_strobe_cyc(n0, 16)); end
        end
        $display("reset_mid: reset during data, then 5a");
    endtask

    task automatic test_disable();
        int n0, busy_before;
        bus.baud_div_i = 32'd8;
        bus.rx_en_i = 1'b0;
        clear_log();
        busy_before = busy_cycles;
        send_frame(8'h66, 8, 1'b1, ^8'h66, 1'b0, n0);
        step(6);
        n_cmp++; if (ev_kind.size() !== 0) begin n_bad++; $display("FAIL disable_count: got %0d want 0", ev_kind.size()); end
        n_cmp++; if (busy_cycles !== busy_before) begin n_bad++; $display("FAIL disable_busy: got %0d busy cycles want 0", busy_cycles - busy_before); end
        bus.rx_en_i = 1'b1;
        step(4);
        $display("disable: frame ignored with rx_en low");
    endtask

    task automatic test_random();
        int n0, baud, k, ek, gap;
        logic [7:0] d;
        bit stop, par, scr;
        for (int i = 0; i < 24; i++) begin
            baud = $urandom_range(0, 20);
            d    = 8'($urandom);
            stop = ($urandom_range(0, 5) != 0);
            par  = (^d) ^ (PAR && ($urandom_range(0, 3) == 0));
            scr  = $urandom_range(0, 1);
            gap  = 6 + $urandom_range(0, 6);
            bus.baud_div_i = baud;
            clear_log();
            send_frame(d, eff_div(baud), stop, par, scr, n0);
            uart_rx = 1'b1;
            step(gap);
            ek = exp_kind(d, stop, par);
            if (ek == 0) exp_data = d;
            k = (ev_kind.size() > 0) ? ev_kind[0] : -1;
            $display("random %0d: baud %0d data %02h stop %0b par %0b -> kind %0d", i, baud, d, stop, par, k);
            n_cmp++; if (ev_kind.size() !== 1) begin n_bad++; $display("FAIL rand_count[%0d]: got %0d want 1", i, ev_kind.size()); end
            if (ev_kind.size() > 0) begin
                n_cmp++; if (ev_kind[0] !== ek) begin n_bad++; $display("FAIL rand_kind[%0d]: got %0d want %0d", i, ev_kind[0], ek); end
                n_cmp++; if (ev_cyc[0] !== exp_strobe_cyc(n0, baud)) begin n_bad++; $display("FAIL rand_cycle[%0d]: got %0d want %0d", i, ev_cyc[0], exp_strobe_cyc(n0, baud)); end
            end
            n_cmp++; if (bus.rx_data_o !== exp_data) begin n_bad++; $display("FAIL rand_data[%0d]: got %02h want %02h", i, bus.rx_data_o, exp_data); end
        end
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic test_parity();
        int n0;
        bus.baud_div_i = 32'd16;
        clear_log();
        send_frame(8'h03, 16, 1'b1, 1'b0, 1'b0, n0);
        step(6);
        n_cmp++; if (ev_kind.size() !== 1 || bus.rx_data_o !== 8'h03) begin n_bad++; $display("FAIL parity_good: got %0d events data %02h want 1 event data 03", ev_kind.size(), bus.rx_data_o); end
        if (ev_kind.size() > 0) begin
            n_cmp++; if (ev_kind[0] !== 0) begin n_bad++; $display("FAIL parity_good_kind: got %0d want 0", ev_kind[0]); end
        end
        clear_log();
        send_frame(8'h03, 16, 1'b1, 1'b1, 1'b0, n0);
        step(6);
        n_cmp++; if (ev_kind.size() !== 1) begin n_bad++; $display("FAIL parity_bad_count: got %0d want 1", ev_kind.size()); end
        if (ev_kind.size() > 0) begin
            n_cmp++; if (ev_kind[0] !== 2) begin n_bad++; $display("FAIL parity_bad_kind: got %0d want 2", ev_kind[0]); end
        end
        n_cmp++; if (bus.rx_data_o !== 8'h03) begin n_bad++; $display("FAIL parity_bad_data: got %02h want 03", bus.rx_data_o); end
        exp_data = 8'h03;
        $display("parity: 03 with parity 0 then 1");
    endtask
`endif

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_basic();
        test_glitch();
        test_frame_error();
        test_back_to_back();
        test_reset_mid();
        test_disable();
`ifdef UART_RX_PARITY_EN
        test_parity();
`endif
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
